byte_packer: RTL

Serial-to-parallel word assembler: accepts a stream of 8-bit bytes over a valid/ready handshake and emits one packed word per NBYTES accepted bytes, also over valid/ready. It is the inverse of the team's word splitter (32-bit word to four bytes O1..O4, O1 = bits [31:24]). It sits on the receive side of byte-wide datapaths and rebuilds words for the register file or memory. A one-entry output buffer lets assembly of the next word overlap a stalled consumer.

---
 rtl/byte_packer_pkg.sv | 10 +
 rtl/byte_packer_if.sv | 24 ++
 rtl/byte_packer_pk_out_buf.sv | 48 ++++
 rtl/byte_packer.sv | 70 +++++++
 4 files changed

// File: rtl/byte_packer_pkg.sv
// Shared constants and width helper for the byte packer.
package byte_packer_pkg;
  localparam int BYTE_W     = 8;
  localparam int CNT_W      = 3;
  localparam int NBYTES_MAX = 8;

  function automatic int word_w(input int nbytes);
    return BYTE_W * nbytes;
  endfunction
endpackage

// File: rtl/byte_packer_if.sv
// Byte-in / word-out valid-ready bundle for byte_packer.
interface byte_packer_if
  import byte_packer_pkg::*;
#(
  parameter int NBYTES = 4
);
  logic [BYTE_W-1:0]         in_byte;
  logic                      in_valid;
  logic                      in_ready;
  logic [word_w(NBYTES)-1:0] out_word;
  logic                      out_valid;
  logic                      out_ready;
  logic [CNT_W-1:0]          fill;

  modport master (
    output in_byte, in_valid, out_ready,
    input  in_ready, out_word, out_valid, fill
  );

  modport slave (
    input  in_byte, in_valid, out_ready,
    output in_ready, out_word, out_valid, fill
  );
endinterface

// File: rtl/byte_packer_pk_out_buf.sv
// One-entry valid/ready output register; a load in the same cycle as a take
// replaces the word without a bubble.
module pk_out_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic [W-1:0] word_o,
  output logic         valid_o,
  output logic         block_o
);
  logic [W-1:0] word_q, word_d;
  logic         valid_q, valid_d;
  logic         take_s;

  assign take_s  = valid_q && ready_i;
  assign block_o = valid_q && !ready_i;
  assign word_o  = word_q;
  assign valid_o = valid_q;

  // Next-state: load wins over take; a plain take only clears valid.
  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    if (load_i) begin
      word_d  = data_i;
      valid_d = 1'b1;
    end else if (take_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q  <= {W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: rtl/byte_packer.sv
// Serial byte stream to NBYTES-wide word assembler with a one-entry output buffer.
// Define BYTE_PACKER_LE_EN for little-endian byte placement (default big-endian).
module byte_packer
  import byte_packer_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic          clk,
  input  logic          reset,
  byte_packer_if.slave  bus
);
  localparam int              W        = word_w(NBYTES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  logic [W-1:0]     asm_q, asm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     shifted_s;
  logic             block_s;
  logic             accept_s;
  logic             final_s;

  // Only a final byte can be held off, and only by a word the consumer refuses.
  assign bus.in_ready = (cnt_q != LAST_IDX) || !block_s;
  assign accept_s     = bus.in_valid && bus.in_ready;
  assign final_s      = accept_s && (cnt_q == LAST_IDX);
  assign bus.fill     = cnt_q;

`ifdef BYTE_PACKER_LE_EN
  assign shifted_s = {bus.in_byte, asm_q[W-1:BYTE_W]};
`else
  assign shifted_s = {asm_q[W-BYTE_W-1:0], bus.in_byte};
`endif

  // Assembly register and byte counter next-state.
  always_comb begin
    asm_d = asm_q;
    cnt_d = cnt_q;
    if (final_s) begin
      asm_d = shifted_s;
      cnt_d = {CNT_W{1'b0}};
    end else if (accept_s) begin
      asm_d = shifted_s;
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Assembly state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      asm_q <= {W{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      asm_q <= asm_d;
      cnt_q <= cnt_d;
    end
  end

  pk_out_buf #(.W(W)) u_out_buf (
    .clk     (clk),
    .reset   (reset),
    .load_i  (final_s),
    .data_i  (shifted_s),
    .ready_i (bus.out_ready),
    .word_o  (bus.out_word),
    .valid_o (bus.out_valid),
    .block_o (block_s)
  );
endmodule
